// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: datapath widths and the write-back request record.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package rv32i_pkg;

  localparam int WORD_WIDTH     = `WORD_WIDTH;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [WORD_WIDTH-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of pending ALU write-backs; exposes per-entry valid and rd
// so the parent can build the register scoreboard.
module wb_fifo #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            push,
  input  logic [ADDR_WIDTH-1:0]           push_rd,
  input  logic [WORD_WIDTH-1:0]           push_data,
  input  logic                            pop,
  output logic [ADDR_WIDTH-1:0]           head_rd,
  output logic [WORD_WIDTH-1:0]           head_data,
  output logic [CNT_W-1:0]                count,
  output logic [DEPTH-1:0]                entry_valid,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count alone, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= push_rd;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly PTR_W bits, so the increment wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is assigned with <= so all flops update together
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset         = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offset} < count_q);
      entry_rd[i]    = rd_mem[i];
    end
  end

  assign head_rd   = rd_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/wb_unit.sv
// Write-back arbiter: merges load results (unbuffered, highest priority) with
// queued ALU results into a single registered register-file write port.
module wb_unit #(
  parameter int ADDR_WIDTH = rv32i_pkg::REG_ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int ALU_DEPTH  = 4,
  localparam int CNT_W     = $clog2(ALU_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [WORD_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  input  logic [ADDR_WIDTH-1:0]      mem_rd,
  input  logic [WORD_WIDTH-1:0]      mem_data,
  output logic                       wb_reg_write,
  output logic [ADDR_WIDTH-1:0]      wb_addr,
  output logic [WORD_WIDTH-1:0]      wb_data,
  output logic [2**ADDR_WIDTH-1:0]   pending,
  output logic [CNT_W-1:0]           alu_count
);

  logic                                 alu_push;
  logic                                 mem_take;
  logic                                 fifo_pop;
  logic [ADDR_WIDTH-1:0]                head_rd;
  logic [WORD_WIDTH-1:0]                head_data;
  logic [ALU_DEPTH-1:0]                 entry_valid;
  logic [ALU_DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd;

  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_WIDTH-1:0] wb_data_q, wb_data_d;

  // Ready comes from the registered count only, so it never depends on a pop.
  assign alu_ready = (alu_count != CNT_W'(ALU_DEPTH));
  assign alu_push  = alu_valid && alu_ready && (alu_rd != '0) && !flush;
  assign mem_take  = mem_valid && (mem_rd != '0);
  assign fifo_pop  = !flush && !mem_take && (alu_count != '0);

  wb_fifo #(
    .DEPTH      (ALU_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_alu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push        (alu_push),
    .push_rd     (alu_rd),
    .push_data   (alu_data),
    .pop         (fifo_pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (alu_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_comb begin
    wb_reg_write_d = 1'b0;
    wb_addr_d      = wb_addr_q;
    wb_data_d      = wb_data_q;
    if (mem_take) begin
      wb_reg_write_d = 1'b1;
      wb_addr_d      = mem_rd;
      wb_data_d      = mem_data;
    end else if (fifo_pop) begin
      wb_reg_write_d = 1'b1;
      wb_addr_d      = head_rd;
      wb_data_d      = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_reg_write_q <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_reg_write_q <= wb_reg_write_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
    end
  end

  // Register x0 is never queued, but bit 0 is forced low regardless.
  always_comb begin
    pending = '0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      if (entry_valid[i]) pending[entry_rd[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign wb_reg_write = wb_reg_write_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register index width.
REQ-002 Parameter WORD_WIDTH, default `WORD_WIDTH (32), data width.
REQ-003 Parameter ALU_DEPTH, default 4, ALU result FIFO entries (power of two, >=2).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 flush  in  1  discard all queued ALU results.
REQ-007 alu_valid / alu_ready  in / out  1 / 1  ALU result handshake.
REQ-008 alu_rd / alu_data  in  ADDR_WIDTH / WORD_WIDTH  ALU destination, value.
REQ-009 mem_valid  in  1  load result present; always accepted (no ready).
REQ-010 mem_rd / mem_data  in  ADDR_WIDTH / WORD_WIDTH  load destination, value.
REQ-011 wb_reg_write  out  1  register file write enable.
REQ-012 wb_addr / wb_data  out  ADDR_WIDTH / WORD_WIDTH  write index, value.
REQ-013 pending  out  2^ADDR_WIDTH  bit r set while a queued ALU entry targets r.
REQ-014 alu_count  out  $clog2(ALU_DEPTH)+1  ALU FIFO occupancy.

Function
REQ-015 ALU transfer occurs on a rising edge where alu_valid and alu_ready are both 1.
REQ-016 alu_ready = (alu_count != ALU_DEPTH), from registered count only; a pop in the same cycle does not raise it.
REQ-017 Accepted ALU results with alu_rd != 0 are pushed into the FIFO in arrival order.
REQ-018 Requests (either source) with rd == 0 are accepted and discarded: no push, no write, no pending bit.
REQ-019 Write output is registered: wb_reg_write/wb_addr/wb_data update only at the rising edge.
REQ-020 Per edge, priority: mem_valid with mem_rd != 0 loads the output register from mem; else if FIFO non-empty, head is popped into it; else wb_reg_write becomes 0.
REQ-021 Mem latency: request at edge N gives wb_reg_write=1 in the cycle after edge N.
REQ-022 ALU latency: push at edge N, earliest output in the cycle after edge N+1; no FIFO bypass.
REQ-023 Simultaneous push and pop in one edge: count unchanged, both take effect.
REQ-024 Mem request while FIFO non-empty: FIFO head held, not popped that edge.
REQ-025 wb_addr/wb_data hold their previous value when wb_reg_write is 0.
REQ-026 pending is combinational: OR over valid FIFO entries of one-hot(rd); bit 0 always 0.
REQ-027 Entries leave pending the edge they are popped.
REQ-028 Ordering is guaranteed within each source only; issuer uses pending to avoid cross-source WAW.
REQ-029 flush at edge N: FIFO emptied, pointers and count zeroed, ALU request that edge discarded, output register loads from mem if mem_valid else wb_reg_write=0.
REQ-030 Read/write pointers wrap modulo ALU_DEPTH.

Reset
REQ-031 rst_n=0 at an edge: count 0, pointers 0, wb_reg_write 0, wb_addr 0, wb_data 0; inputs ignored.
REQ-032 Reset has priority over flush and all transfers; after reset alu_ready=1, pending=0.
REQ-033 FIFO storage is not reset; only valid state is.

Structure
REQ-034 Shared package rv32i_pkg holds WORD_WIDTH, REG_ADDR_WIDTH and struct wb_req_t {rd, data}.
REQ-035 One sub-module wb_fifo (parameterised depth, push/pop/flush, count, per-entry valid+rd exposed for pending).
REQ-036 wb_unit outputs connect directly to reg_file regWrite/write_addr/data_in.

Verification
REQ-037 Mem rd=5 data=0xDEADBEEF at edge 1 -> wb_reg_write=1, wb_addr=5, wb_data=0xDEADBEEF after edge 1 only.
REQ-038 Five back-to-back ALU pushes rd=1..5 with mem_valid held 1 (rd=7) -> alu_ready=0 after 4th push, pending=0x1E, count 4.
REQ-039 Drop mem_valid after REQ-038 -> writes rd=1,2,3,4 in consecutive cycles, then 5th accepted, pending clears bit by bit.
REQ-040 ALU rd=0 and mem rd=0 requests -> no write, count unchanged, pending 0.
REQ-041 Three ALU entries queued, flush=1 with mem rd=9 -> count 0, pending 0, next write rd=9, no stale ALU writes.
REQ-042 rst_n=0 mid-drain with 2 queued -> wb_reg_write=0, count 0, alu_ready=1 next cycle.
